// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: branch/jump redirect, load-use stall and data-memory
// handshake hold with a 15-cycle timeout, sticky error flag and saturating redirect count.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memwr_m,
  input  logic        memrd_m,
  input  logic        bbne_m,
  input  logic        bbeq_m,
  input  logic        bblez_m,
  input  logic        bbgtz_m,
  input  logic        jump_m,
  input  logic        zero_m,
  input  logic        neg_m,
  input  logic        memrd_e,
  input  logic [4:0]  rt_e,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic        dmem_ack,
  output logic        pc_we,
  output logic        ifid_we,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        pipe_hold,
  output logic        pc_src,
  output logic        dmem_req,
  output logic        mem_err,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN = 1'b0, MEM_WAIT = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_err_q;
  logic [15:0] flush_cnt_q;
  logic        taken, loaduse, hold, timeout, redirect;

  assign taken = jump_m | (bbeq_m & zero_m) | (bbne_m & ~zero_m) |
                 (bblez_m & (zero_m | neg_m)) | (bbgtz_m & ~zero_m & ~neg_m);
  assign loaduse = memrd_e & (rt_e != 5'd0) & ((rt_e == rs_d) | (rt_e == rt_d));

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hold        = 1'b0;
    timeout     = 1'b0;
    redirect    = 1'b0;
    dmem_req    = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pipe_hold   = 1'b0;
    pc_src      = 1'b0;
    if (!rst_n) begin
      // Reset drains every pipeline register and freezes fetch.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      dmem_req = (state_q == MEM_WAIT) | memrd_m | memwr_m;
      case (state_q)
        RUN: begin
          if (dmem_req && !dmem_ack) begin
            hold       = 1'b1;
            state_d    = MEM_WAIT;
            wait_cnt_d = 4'd0;
          end
        end
        MEM_WAIT: begin
          if (dmem_ack) begin
            state_d = RUN;
          end else if (wait_cnt_q == 4'd14) begin
            timeout = 1'b1;
            state_d = RUN;
          end else begin
            hold       = 1'b1;
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end
        default: state_d = RUN;
      endcase

      // Memory hold outranks redirect, which outranks the load-use bubble.
      if (hold) begin
        pipe_hold = 1'b1;
      end else if (taken) begin
        redirect    = 1'b1;
        pc_src      = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
      end else if (loaduse) begin
        idex_flush = 1'b1;
      end else begin
        pc_we   = 1'b1;
        ifid_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= 4'd0;
      mem_err_q   <= 1'b0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout) mem_err_q <= 1'b1;
      if (redirect && flush_cnt_q != 16'hFFFF) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign mem_err   = mem_err_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations are queued by the driver and
// checked by an independent monitor on the falling edge.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memwr_m, memrd_m, bbne_m, bbeq_m, bblez_m, bbgtz_m, jump_m;
  logic        zero_m, neg_m, memrd_e, dmem_ack;
  logic [4:0]  rt_e, rs_d, rt_d;
  logic        pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush;
  logic        pipe_hold, pc_src, dmem_req, mem_err;
  logic [15:0] flush_cnt;

  // {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_src, dmem_req}
  localparam logic [7:0] NORM     = 8'b11000000;
  localparam logic [7:0] NORM_REQ = 8'b11000001;
  localparam logic [7:0] TAKEN    = 8'b11111010;
  localparam logic [7:0] TAKEN_RQ = 8'b11111011;
  localparam logic [7:0] STALL    = 8'b00010000;
  localparam logic [7:0] HOLD     = 8'b00000101;
  localparam logic [7:0] RST      = 8'b00111000;

  typedef struct packed {
    logic [7:0]  o;
    logic        err;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .memwr_m(memwr_m), .memrd_m(memrd_m), .bbne_m(bbne_m), .bbeq_m(bbeq_m),
    .bblez_m(bblez_m), .bbgtz_m(bbgtz_m), .jump_m(jump_m),
    .zero_m(zero_m), .neg_m(neg_m), .memrd_e(memrd_e), .rt_e(rt_e),
    .rs_d(rs_d), .rt_d(rt_d), .dmem_ack(dmem_ack),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .pipe_hold(pipe_hold),
    .pc_src(pc_src), .dmem_req(dmem_req), .mem_err(mem_err), .flush_cnt(flush_cnt)
  );

  // Monitor: the DUT presents a full output word every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e   = exp_q.pop_front();
      act = {pc_we, ifid_we, ifid_flush, idex_flush, exmem_flush, pipe_hold, pc_src, dmem_req};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL ctl_outs t=%0t got=%b want=%b", $time, act, e.o);
      end
      checks++;
      if (mem_err !== e.err) begin
        errors++;
        $display("FAIL mem_err t=%0t got=%b want=%b", $time, mem_err, e.err);
      end
      checks++;
      if (flush_cnt !== e.fc) begin
        errors++;
        $display("FAIL flush_cnt t=%0t got=%0d want=%0d", $time, flush_cnt, e.fc);
      end
    end
  end

  task automatic clr_in();
    memwr_m = 0; memrd_m = 0; bbne_m = 0; bbeq_m = 0; bblez_m = 0; bbgtz_m = 0;
    jump_m = 0; zero_m = 0; neg_m = 0; memrd_e = 0; dmem_ack = 0;
    rt_e = 0; rs_d = 0; rt_d = 0;
  endtask

  // Queue the expected response for the inputs just applied, then advance one cycle.
  task automatic cyc(input logic [7:0] o, input logic err, input logic [15:0] fc);
    exp_t e;
    e.o = o; e.err = err; e.fc = fc;
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  initial begin
    clr_in();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(RST, 0, 16'd0);
    rst_n = 1'b1;
    cyc(NORM, 0, 16'd0);

    // Branch condition decode
    bbeq_m = 1; zero_m = 1;          cyc(TAKEN, 0, 16'd0);
    clr_in();                        cyc(NORM,  0, 16'd1);
    bbeq_m = 1;                      cyc(NORM,  0, 16'd1);
    clr_in(); bbne_m = 1;            cyc(TAKEN, 0, 16'd1);
    clr_in(); bblez_m = 1; neg_m = 1; cyc(TAKEN, 0, 16'd2);
    clr_in(); bbgtz_m = 1;           cyc(TAKEN, 0, 16'd3);
    neg_m = 1;                       cyc(NORM,  0, 16'd4);
    clr_in(); bblez_m = 1;           cyc(NORM,  0, 16'd4);

    // Load-use detection
    clr_in(); memrd_e = 1; rt_e = 5; rs_d = 5; cyc(STALL, 0, 16'd4);
    rt_e = 0; rs_d = 0;                        cyc(NORM,  0, 16'd4);
    rt_e = 7; rt_d = 7; rs_d = 2;              cyc(STALL, 0, 16'd4);
    rs_d = 3; rt_d = 4;                        cyc(NORM,  0, 16'd4);
    rs_d = 7; jump_m = 1;                      cyc(TAKEN, 0, 16'd4);
    clr_in();                                  cyc(NORM,  0, 16'd5);

    // Load with ack on the 4th cycle; pending jump and load-use are held off
    memrd_m = 1; jump_m = 1; memrd_e = 1; rt_e = 9; rs_d = 9;
    cyc(HOLD, 0, 16'd5);
    cyc(HOLD, 0, 16'd5);
    cyc(HOLD, 0, 16'd5);
    dmem_ack = 1;                    cyc(TAKEN_RQ, 0, 16'd5);
    clr_in();                        cyc(NORM, 0, 16'd6);
    memwr_m = 1; dmem_ack = 1;       cyc(NORM_REQ, 0, 16'd6);

    // Store that is never acknowledged
    clr_in(); memwr_m = 1;
    for (int i = 0; i < 15; i++) cyc(HOLD, 0, 16'd6);
    cyc(NORM_REQ, 0, 16'd6);
    clr_in();                        cyc(NORM, 1, 16'd6);
    bbne_m = 1;                      cyc(TAKEN, 1, 16'd6);
    clr_in();                        cyc(NORM, 1, 16'd7);

    // Reset in the 5th MEM_WAIT cycle
    memrd_m = 1;
    for (int i = 0; i < 5; i++) cyc(HOLD, 1, 16'd7);
    rst_n = 1'b0;                    cyc(RST, 0, 16'd0);
    rst_n = 1'b1; memrd_m = 0;       cyc(NORM, 0, 16'd0);
    memrd_m = 1; dmem_ack = 1;       cyc(NORM_REQ, 0, 16'd0);

    // Saturation of the redirect counter
    clr_in(); jump_m = 1;
    repeat (65534) begin
      @(posedge clk); #1;
    end
    cyc(TAKEN, 0, 16'd65534);
    cyc(TAKEN, 0, 16'hFFFF);
    clr_in();                        cyc(NORM, 0, 16'hFFFF);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
